// File: rtl/nios_mailbox_pkg.sv
// Shared definitions for the Nios II hardware mailbox: register map and STATUS layout.
package nios_mailbox_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA   = 2'd0,
    ADDR_STATUS = 2'd1,
    ADDR_CLEAR  = 2'd2,
    ADDR_RSVD   = 2'd3
  } addr_e;

  // STATUS register layout; unlisted bits read as 0
  localparam int STATUS_W     = 20;
  localparam int ST_COUNT_LSB = 0;
  localparam int ST_COUNT_W   = 9;
  localparam int ST_EMPTY     = 16;
  localparam int ST_FULL      = 17;
  localparam int ST_ERR       = 18;
  localparam int ST_IRQ_EN    = 19;

endpackage

// File: rtl/mailbox_fifo.sv
// Synchronous show-ahead FIFO: dout always presents the head entry.
// Pointers wrap naturally; occupancy is tracked by a separate counter.
module mailbox_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage array, kept free of reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; flush discards all entries
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/nios_mailbox_slave.sv
// Avalon-MM mailbox slave: blocking push/pop through DATA, bounded stall with
// forced completion on timeout, STATUS/CLEAR control and a level interrupt.
module nios_mailbox_slave
  import nios_mailbox_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 1024
) (
  input  logic              clock_clk,
  input  logic              reset_reset,
  input  logic [1:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_waitrequest,
  output logic              ins_irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(MAX_WAIT + 1);

  addr_e             addr;
  logic              is_wr, is_rd, stall_cond, timeout, accept;
  logic              push, pop, flush;
  logic [WW-1:0]     wait_cnt;
  logic              err, irq_en;
  logic [DATA_W-1:0] fifo_dout;
  logic [AW:0]       count;
  logic              full, empty;
  logic [STATUS_W-1:0] status;

  // A simultaneous read+write is treated as a write
  assign addr       = addr_e'(avs_address);
  assign is_wr      = avs_write;
  assign is_rd      = avs_read & ~avs_write;
  assign stall_cond = (addr == ADDR_DATA) & ((is_wr & full) | (is_rd & empty));
  assign timeout    = stall_cond & (wait_cnt == WW'(MAX_WAIT));
  assign avs_waitrequest = stall_cond & (wait_cnt < WW'(MAX_WAIT));
  assign accept     = (is_wr | is_rd) & ~avs_waitrequest;

  // A timed-out access completes without touching the FIFO
  assign push  = accept & is_wr & (addr == ADDR_DATA) & ~timeout;
  assign pop   = accept & is_rd & (addr == ADDR_DATA) & ~timeout;
  assign flush = accept & is_wr & (addr == ADDR_CLEAR);

  mailbox_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
    .clk   (clock_clk),
    .rst   (reset_reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (avs_writedata),
    .dout  (fifo_dout),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Assemble the STATUS word
  always_comb begin
    status = '0;
    status[ST_COUNT_LSB +: AW+1] = count;
    status[ST_EMPTY]  = empty;
    status[ST_FULL]   = full;
    status[ST_ERR]    = err;
    status[ST_IRQ_EN] = irq_en;
  end

  // Stall counter: counts stalled cycles, clears on acceptance or idle
  always_ff @(posedge clock_clk) begin
    if (reset_reset)          wait_cnt <= '0;
    else if (avs_waitrequest) wait_cnt <= wait_cnt + 1'b1;
    else                      wait_cnt <= '0;
  end

  // Sticky ERR and IRQ_EN control
  always_ff @(posedge clock_clk) begin
    if (reset_reset) begin
      err    <= 1'b0;
      irq_en <= 1'b0;
    end else if (accept && is_wr && addr == ADDR_STATUS) begin
      irq_en <= avs_writedata[ST_IRQ_EN];
      if (avs_writedata[ST_ERR]) err <= 1'b0;
    end else if (flush) begin
      err <= 1'b0;
    end else if (timeout) begin
      err <= 1'b1;
    end
  end

  // Read data register: loads only on an accepted read, holds otherwise
  always_ff @(posedge clock_clk) begin
    if (reset_reset) begin
      avs_readdata <= '0;
    end else if (accept && is_rd) begin
      case (addr)
        ADDR_DATA:   avs_readdata <= timeout ? '0 : fifo_dout;
        ADDR_STATUS: avs_readdata <= DATA_W'(status);
        default:     avs_readdata <= '0;
      endcase
    end
  end

  // Registered interrupt, one cycle behind the occupancy change
  always_ff @(posedge clock_clk) begin
    if (reset_reset) ins_irq <= 1'b0;
    else             ins_irq <= irq_en & ~empty;
  end

endmodule

// File: tb/tb_nios_mailbox_slave.sv
// Directed bench for nios_mailbox_slave (DEPTH=16, MAX_WAIT=8).
module tb_nios_mailbox_slave;

  localparam logic [1:0] A_DATA = 2'd0, A_STATUS = 2'd1, A_CLEAR = 2'd2, A_RSVD = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata, avs_readdata;
  logic        avs_waitrequest, ins_irq;

  int errors = 0;
  int checks = 0;
  int st;

  always #5 clk = ~clk;

  nios_mailbox_slave #(.DEPTH(16), .DATA_W(32), .MAX_WAIT(8)) dut (
    .clock_clk       (clk),
    .reset_reset     (rst),
    .avs_address     (avs_address),
    .avs_read        (avs_read),
    .avs_write       (avs_write),
    .avs_writedata   (avs_writedata),
    .avs_readdata    (avs_readdata),
    .avs_waitrequest (avs_waitrequest),
    .ins_irq         (ins_irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts and ends 1 time unit after a rising edge; returns stalled cycles
  task automatic access(input logic [1:0] a, input logic w, input logic [31:0] d,
                        output int stalls);
    avs_address = a; avs_write = w; avs_read = ~w; avs_writedata = d;
    stalls = 0;
    #1;
    while (avs_waitrequest && stalls < 100) begin
      @(posedge clk); #1; stalls++;
    end
    @(posedge clk); #1;
    avs_read = 1'b0; avs_write = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; avs_address = A_DATA; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_readdata", avs_readdata, 32'h0);
    chk("rst_irq", {31'd0, ins_irq}, 32'h0);
    chk("rst_wait_idle", {31'd0, avs_waitrequest}, 32'h0);
    avs_read = 1'b1;
    #1;
    chk("rst_wait_rd_empty", {31'd0, avs_waitrequest}, 32'h1);
    avs_read = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic push/pop ordering
    access(A_DATA, 1, 32'hA5A5_0001, st);
    chk("push1_stalls", st, 0);
    access(A_DATA, 1, 32'hA5A5_0002, st);
    access(A_DATA, 1, 32'hA5A5_0003, st);
    access(A_STATUS, 0, 0, st);
    chk("status_cnt3", avs_readdata, 32'h0000_0003);
    access(A_DATA, 0, 0, st);
    chk("pop1", avs_readdata, 32'hA5A5_0001);
    access(A_DATA, 0, 0, st);
    chk("pop2", avs_readdata, 32'hA5A5_0002);
    access(A_DATA, 0, 0, st);
    chk("pop3", avs_readdata, 32'hA5A5_0003);
    @(posedge clk); #1;
    chk("readdata_hold", avs_readdata, 32'hA5A5_0003);
    access(A_RSVD, 0, 0, st);
    chk("rsvd_read", avs_readdata, 32'h0);
    chk("rsvd_nostall", st, 0);

    // Fill to full (pointers wrap), then stall a 17th write
    for (int i = 0; i < 16; i++) access(A_DATA, 1, 32'h100 + i, st);
    access(A_STATUS, 0, 0, st);
    chk("status_full", avs_readdata, 32'h0002_0010);
    avs_address = A_DATA; avs_write = 1'b1; avs_writedata = 32'h999;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("full_stall", {31'd0, avs_waitrequest}, 32'h1);
      @(posedge clk); #1;
    end
    avs_write = 1'b0;
    access(A_DATA, 0, 0, st);
    chk("pop_head", avs_readdata, 32'h100);
    access(A_DATA, 1, 32'h999, st);
    chk("write_after_pop", st, 0);
    access(A_STATUS, 0, 0, st);
    chk("status_refull", avs_readdata, 32'h0002_0010);

    // Timed-out write: dropped, ERR set, queue untouched
    access(A_DATA, 1, 32'hDEAD, st);
    chk("wr_timeout_stalls", st, 8);
    access(A_STATUS, 0, 0, st);
    chk("status_err_full", avs_readdata, 32'h0006_0010);
    access(A_DATA, 0, 0, st);
    chk("pop_after_drop", avs_readdata, 32'h101);

    // CLEAR flushes and clears ERR; then a timed-out read
    access(A_CLEAR, 1, 0, st);
    access(A_STATUS, 0, 0, st);
    chk("status_cleared", avs_readdata, 32'h0001_0000);
    access(A_DATA, 0, 0, st);
    chk("rd_timeout_stalls", st, 8);
    chk("rd_timeout_data", avs_readdata, 32'h0);
    access(A_STATUS, 0, 0, st);
    chk("status_err_empty", avs_readdata, 32'h0005_0000);
    access(A_STATUS, 1, 32'h0004_0000, st);
    access(A_STATUS, 0, 0, st);
    chk("status_err_w1c", avs_readdata, 32'h0001_0000);
    access(A_CLEAR, 0, 0, st);
    chk("clear_read", avs_readdata, 32'h0);

    // Interrupt
    access(A_STATUS, 1, 32'h0008_0000, st);
    access(A_STATUS, 0, 0, st);
    chk("status_irq_en", avs_readdata, 32'h0009_0000);
    access(A_DATA, 1, 32'h77, st);
    chk("irq_lag_rise", {31'd0, ins_irq}, 32'h0);
    @(posedge clk); #1;
    chk("irq_high", {31'd0, ins_irq}, 32'h1);
    access(A_DATA, 0, 0, st);
    chk("irq_pop_data", avs_readdata, 32'h77);
    chk("irq_lag_fall", {31'd0, ins_irq}, 32'h1);
    @(posedge clk); #1;
    chk("irq_low", {31'd0, ins_irq}, 32'h0);

    // Push 5, CLEAR, then a DATA read stalls
    for (int i = 0; i < 5; i++) access(A_DATA, 1, 32'h200 + i, st);
    access(A_CLEAR, 1, 0, st);
    access(A_STATUS, 0, 0, st);
    chk("status_after_clear", avs_readdata, 32'h0009_0000);
    avs_address = A_DATA; avs_read = 1'b1;
    #1;
    chk("clear_then_stall", {31'd0, avs_waitrequest}, 32'h1);
    avs_read = 1'b0;
    @(posedge clk); #1;

    // Reset during a stalled read: access stays pending, counter restarts
    avs_address = A_DATA; avs_read = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_readdata", avs_readdata, 32'h0);
    chk("midrst_irq", {31'd0, ins_irq}, 32'h0);
    chk("midrst_stall", {31'd0, avs_waitrequest}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;
    access(A_DATA, 0, 0, st);
    chk("midrst_timeout_stalls", st, 8);
    chk("midrst_timeout_data", avs_readdata, 32'h0);
    access(A_STATUS, 0, 0, st);
    chk("status_post_rst", avs_readdata, 32'h0005_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
